// File: rtl/pipe_ctrl.sv
// pipe_ctrl: stall merge, exception/ERET drain-and-flush sequencing, stall-cycle counter
module pipe_ctrl #(
  parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        stallreq_if,
  input  logic        stallreq_id,
  input  logic        stallreq_exe,
  input  logic        stallreq_mem,
  input  logic        exc_valid,
  input  logic        exc_is_eret,
  input  logic [31:0] exc_epc,
  input  logic        ibus_busy,
  input  logic        dbus_busy,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] flush_pc,
  output logic        ctrl_busy,
  output logic [31:0] stall_cnt,
  input  logic        stall_cnt_clr
);
  typedef enum logic [1:0] {IDLE, DRAIN, FLUSH} state_t;
  state_t state, state_n;
  logic [31:0] tgt, tgt_in;
  logic [5:0] merge;
  logic bus_idle;
  assign bus_idle  = !ibus_busy && !dbus_busy;
  assign tgt_in    = exc_is_eret ? exc_epc : EXC_VECTOR;
  assign flush     = (state == FLUSH);
  assign ctrl_busy = resetn && (state != IDLE);
  // next state and stall bus; exceptions freeze everything, otherwise highest requester wins
  always_comb begin
    merge   = stallreq_mem ? 6'b011111 : stallreq_exe ? 6'b001111 :
              stallreq_id  ? 6'b000111 : stallreq_if  ? 6'b000011 : 6'b000000;
    state_n = state;
    stall   = 6'b000000;
    if (state == IDLE) begin
      stall   = exc_valid ? 6'b111111 : merge;
      state_n = !exc_valid ? IDLE : bus_idle ? FLUSH : DRAIN;
    end else if (state == DRAIN) begin
      stall   = 6'b111111;
      state_n = bus_idle ? FLUSH : DRAIN;
    end else begin
      state_n = IDLE;
    end
    if (!resetn) stall = 6'b000000;
  end
  // state register; reset aborts any redirect in progress
  always_ff @(posedge clk) begin
    if (!resetn) state <= IDLE;
    else state <= state_n;
  end
  // capture the redirect target on acceptance and publish it for the flush cycle
  always_ff @(posedge clk) begin
    if (!resetn) begin
      tgt      <= '0;
      flush_pc <= '0;
    end else begin
      if (state == IDLE && exc_valid) tgt <= tgt_in;
      if (state_n == FLUSH) flush_pc <= (state == IDLE) ? tgt_in : tgt;
    end
  end
  // saturating count of cycles in which the PC is held; clear beats increment
  always_ff @(posedge clk) begin
    if (!resetn || stall_cnt_clr) stall_cnt <= '0;
    else if (stall[0] && !(&stall_cnt)) stall_cnt <= stall_cnt + 32'd1;
  end
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: randomized scoreboard bench for pipe_ctrl against a behavioural model
module tb_pipe_ctrl;
  localparam logic [31:0] VEC = 32'hBFC0_0380;
  logic clk = 0;
  always #5 clk = ~clk;
  logic resetn, stallreq_if, stallreq_id, stallreq_exe, stallreq_mem;
  logic exc_valid, exc_is_eret, ibus_busy, dbus_busy, stall_cnt_clr;
  logic [31:0] exc_epc, flush_pc, stall_cnt;
  logic [5:0] stall;
  logic flush, ctrl_busy;
  pipe_ctrl dut (
    .clk(clk), .resetn(resetn),
    .stallreq_if(stallreq_if), .stallreq_id(stallreq_id),
    .stallreq_exe(stallreq_exe), .stallreq_mem(stallreq_mem),
    .exc_valid(exc_valid), .exc_is_eret(exc_is_eret), .exc_epc(exc_epc),
    .ibus_busy(ibus_busy), .dbus_busy(dbus_busy),
    .stall(stall), .flush(flush), .flush_pc(flush_pc),
    .ctrl_busy(ctrl_busy), .stall_cnt(stall_cnt), .stall_cnt_clr(stall_cnt_clr)
  );
  typedef struct {
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] pc;
    logic        busy;
    logic [31:0] cnt;
    bit          full;
  } exp_t;
  exp_t q[$];
  int tests = 0, fails = 0;
  // reference model: a redirect is either waiting on the buses or due to flush next cycle
  bit m_pend = 0, m_due = 0;
  logic [31:0] m_tgt = '0, m_pc = '0, m_cnt = '0;
  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
    end
  endtask
  task automatic step(bit full = 1);
    exp_t e;
    int k;
    e.full = full;
    e.flush = m_due;
    e.pc = m_pc;
    e.cnt = m_cnt;
    e.busy = 0;
    if (!resetn) begin
      e.stall = 0;
      m_pend = 0; m_due = 0; m_pc = 0; m_tgt = 0; m_cnt = 0;
    end else begin
      e.busy = m_due || m_pend;
      if (m_due) begin
        e.stall = 0;
        m_due = 0;
      end else if (m_pend || exc_valid) begin
        e.stall = 6'h3f;
        if (!m_pend) m_tgt = exc_is_eret ? exc_epc : VEC;
        if (!ibus_busy && !dbus_busy) begin
          m_pend = 0; m_due = 1; m_pc = m_tgt;
        end else m_pend = 1;
      end else begin
        k = -1;
        if (stallreq_if) k = 0;
        if (stallreq_id) k = 1;
        if (stallreq_exe) k = 2;
        if (stallreq_mem) k = 3;
        e.stall = (k < 0) ? 6'd0 : 6'((1 << (k + 2)) - 1);
      end
      if (stall_cnt_clr) m_cnt = 0;
      else if (e.stall[0] && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
    end
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask
  task automatic idle_inputs();
    {stallreq_if, stallreq_id, stallreq_exe, stallreq_mem} = '0;
    {exc_valid, exc_is_eret, ibus_busy, dbus_busy, stall_cnt_clr} = '0;
    exc_epc = '0;
  endtask
  // monitor: pops one expectation per presented cycle and compares away from the edge
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("stall", 32'(stall), 32'(e.stall));
        chk("ctrl_busy", 32'(ctrl_busy), 32'(e.busy));
        if (e.full) begin
          chk("flush", 32'(flush), 32'(e.flush));
          chk("flush_pc", flush_pc, e.pc);
          chk("stall_cnt", stall_cnt, e.cnt);
        end
      end
    end
  end
  initial begin
    resetn = 0;
    {stallreq_if, stallreq_id, stallreq_exe, stallreq_mem} = '1;
    {exc_valid, exc_is_eret, ibus_busy, dbus_busy, stall_cnt_clr} = '1;
    exc_epc = '1;
    @(posedge clk); #1;
    step(0);
    step();
    resetn = 1;
    idle_inputs();
    step();
    stallreq_id = 1; step();
    stallreq_exe = 1; step();
    stallreq_mem = 1; step();
    {stallreq_id, stallreq_exe, stallreq_mem} = '0; stallreq_if = 1; step();
    stallreq_if = 0; step();
    exc_valid = 1; stallreq_exe = 1; step();
    exc_valid = 0; stallreq_exe = 0; step();
    step();
    exc_valid = 1; exc_is_eret = 1; exc_epc = 32'h8000_1234; dbus_busy = 1; step();
    exc_valid = 0; step();
    step();
    dbus_busy = 0; step();
    step();
    step();
    exc_valid = 1; exc_is_eret = 0; ibus_busy = 1;
    repeat (3) step();
    ibus_busy = 0; step();
    exc_valid = 0; step();
    step();
    exc_valid = 1; ibus_busy = 1; step();
    exc_valid = 0; step();
    resetn = 0; step();
    resetn = 1; ibus_busy = 0; stallreq_id = 1; step();
    step();
    stallreq_id = 0; stall_cnt_clr = 1; step();
    stall_cnt_clr = 0; stallreq_if = 1;
    repeat (5) step();
    stallreq_if = 0; step();
    force dut.stall_cnt = 32'hFFFF_FFFE;
    #1 release dut.stall_cnt;
    m_cnt = 32'hFFFF_FFFE;
    stallreq_if = 1;
    repeat (3) step();
    stallreq_if = 0; step();
    stallreq_if = 1; stall_cnt_clr = 1; step();
    stallreq_if = 0; stall_cnt_clr = 0; step();
    for (int i = 0; i < 2000; i++) begin
      resetn = ($urandom_range(63) != 0);
      {stallreq_if, stallreq_id, stallreq_exe, stallreq_mem} = 4'($urandom);
      exc_valid = ($urandom_range(7) == 0);
      exc_is_eret = $urandom_range(1);
      exc_epc = $urandom;
      ibus_busy = ($urandom_range(2) == 0);
      dbus_busy = ($urandom_range(2) == 0);
      stall_cnt_clr = ($urandom_range(31) == 0);
      step();
    end
    resetn = 1;
    idle_inputs();
    step();
    step();
    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline stall/flush controller for the dual-issue MIPS core. Each cycle it merges the per-stage stall requests into the stage stall bus consumed by the PC and the IF/ID, ID/EXE, EXE/MEM and MEM/WB pipeline registers. It sequences precise-exception and ERET redirects by freezing the pipe, waiting for in-flight bus transactions to drain, then issuing a one-cycle flush with the redirect PC. It also keeps a saturating stall-cycle performance counter.

## Interface
Parameters:
- EXC_VECTOR, 32'hBFC0_0380, redirect target for all non-ERET exceptions

Ports:
- clk  in  1  core clock; all state updates on posedge
- resetn  in  1  reset; one clock, synchronous, active-low
- stallreq_if  in  1  IF stage stall request (icache miss)
- stallreq_id  in  1  ID stage stall request (load-use hazard)
- stallreq_exe  in  1  EXE stage stall request (mul/div busy)
- stallreq_mem  in  1  MEM stage stall request (dcache busy)
- exc_valid  in  1  MEM-stage exception or ERET committing this cycle
- exc_is_eret  in  1  qualifies exc_valid: redirect to exc_epc
- exc_epc  in  32  CP0 EPC value, sampled with exc_valid
- ibus_busy  in  1  instruction bus transaction outstanding
- dbus_busy  in  1  data bus transaction outstanding
- stall  out  6  stall bus, 1 = PIPELINE_STOP; bit 0 PC, 1 IF/ID, 2 ID/EXE, 3 EXE/MEM, 4 MEM/WB, 5 WB
- flush  out  1  flush all pipeline registers, registered
- flush_pc  out  32  redirect PC, valid while flush=1, registered
- ctrl_busy  out  1  1 while the exception FSM is not IDLE
- stall_cnt  out  32  cycles with stall[0]=1, saturating
- stall_cnt_clr  in  1  synchronous clear of stall_cnt

## Operation
- FSM states: IDLE, DRAIN, FLUSH.
- IDLE, exc_valid=0: stall is the priority merge of the requests. The highest requesting stage wins.
  - stallreq_mem gives 6'b011111.
  - else stallreq_exe gives 6'b001111.
  - else stallreq_id gives 6'b000111.
  - else stallreq_if gives 6'b000011.
  - else 6'b000000.
  - The stage k with stall[k]=1 and stall[k+1]=0 inserts a bubble.
- IDLE, exc_valid=1: stall=6'b111111 combinationally, and stall requests are ignored. The target is latched as exc_is_eret ? exc_epc : EXC_VECTOR.
  - If ibus_busy=0 and dbus_busy=0, next state is FLUSH.
  - Otherwise next state is DRAIN.
- DRAIN: stall=6'b111111; exc_valid and stall requests are ignored. Leave for FLUSH in the first cycle where ibus_busy=0 and dbus_busy=0.
- FLUSH: flush=1 and flush_pc=latched target; stall=6'b000000; exc_valid is ignored. Next state is always IDLE.
- ctrl_busy = (state != IDLE).
- stall_cnt: +1 on each cycle with stall[0]=1 (DRAIN included) and holds at 32'hFFFF_FFFF. stall_cnt_clr has priority over increment.
- flush_pc holds its last value outside FLUSH.

## Timing
- Reset (resetn=0 at posedge): state=IDLE, flush=0, flush_pc=0, stall_cnt=0. stall is forced to 6'b000000 while resetn=0; ctrl_busy=0.
- Reset mid-DRAIN or mid-FLUSH aborts the sequence: IDLE next cycle, no flush pulse.
- The stall merge is combinational: zero-cycle latency from request to stall.
- Exception with idle buses: exc_valid at cycle N gives stall=all at N and flush=1 at N+1, for exactly one cycle.
- Exception with busy buses: flush rises in the cycle after the first cycle in which both busy flags are 0. The freeze covers N through that cycle.
- Simultaneous exc_valid and any stallreq in IDLE: the exception wins and stall=6'b111111.
- exc_valid held high across several cycles produces exactly one flush. A new exc_valid is only accepted in IDLE, from the cycle after FLUSH onward.
- stall_cnt updates one cycle after the counted cycle.

## Test plan
- Reset with all inputs high -> stall=0, flush=0, flush_pc=0, stall_cnt=0, ctrl_busy=0.
- Priority merge: stallreq_id=1 alone -> 6'b000111; add stallreq_exe -> 6'b001111; add stallreq_mem -> 6'b011111; stallreq_if alone -> 6'b000011; none -> 6'b000000.
- Exception with idle buses: exc_valid=1, exc_is_eret=0 at cycle N.
  - Cycle N: stall=6'b111111.
  - Cycle N+1: flush=1, flush_pc=32'hBFC0_0380, stall=0.
  - Cycle N+2: flush=0, ctrl_busy=0.
- ERET with dbus_busy=1 for 3 cycles: exc_is_eret=1, exc_epc=32'h8000_1234.
  - stall=6'b111111 for 4 cycles.
  - Then one cycle of flush=1 with flush_pc=32'h8000_1234.
- Reset mid-DRAIN: resetn=0 for one cycle while in DRAIN -> no flush pulse, IDLE, stall follows requests.
- Counter: stallreq_if high for 5 cycles -> stall_cnt=5. Preload by forcing 32'hFFFF_FFFE, then 3 stall cycles -> 32'hFFFF_FFFF. stall_cnt_clr together with a stall -> 0.
